framebuffer_writer: RTL and testbench

- Consumer end of the rasterizer pixel stream. Accepts (x, y, drawing) pixels and clips them to the framebuffer bounds.
- Converts surviving pixels to linear BRAM addresses and drives a single write port.
- Also provides a framebuffer clear engine with a start/busy/done handshake; the clear sweeps every address with a fill colour.
- Sits between the rasterizer and the framebuffer BRAM write port.

---
 rtl/framebuffer_writer.sv | 191 +++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
// framebuffer_writer
//   Consumer end of the rasterizer pixel stream. Pixels are clipped against
//   the framebuffer bounds, converted to linear addresses and written through
//   a single BRAM write port. A clear engine sweeps every address with a
//   latched fill colour under a start/busy/done handshake.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   x_in, y_in              signed integer pixel coordinates
//   drawing_in, color_in    pixel valid qualifier and colour (no backpressure)
//   start_clear             clear request pulse (ignored while a clear runs)
//   clear_color             fill colour, captured when a clear is accepted
//   addr_out, data_out      BRAM write address / data
//   we_out                  BRAM write enable
//   busy, done              clear in progress / one-cycle clear completion
//   clip_count, drop_count  saturating off-screen / clear-collision counts
module framebuffer_writer #(
  parameter int COORD_WIDTH = 32,
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 180,
  parameter int COLOR_WIDTH = 16,
  parameter int ADDR_WIDTH  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic signed [COORD_WIDTH-1:0] x_in,
  input  logic signed [COORD_WIDTH-1:0] y_in,
  input  logic                          drawing_in,
  input  logic [COLOR_WIDTH-1:0]        color_in,
  input  logic                          start_clear,
  input  logic [COLOR_WIDTH-1:0]        clear_color,
  output logic [ADDR_WIDTH-1:0]         addr_out,
  output logic [COLOR_WIDTH-1:0]        data_out,
  output logic                          we_out,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   clip_count,
  output logic [15:0]                   drop_count
);

  localparam int                            FB_SIZE   = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0]         LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]         ROW_PITCH = ADDR_WIDTH'(FB_WIDTH);
  localparam logic signed [COORD_WIDTH-1:0] X_LIMIT   = COORD_WIDTH'(FB_WIDTH);
  localparam logic signed [COORD_WIDTH-1:0] Y_LIMIT   = COORD_WIDTH'(FB_HEIGHT);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWEEP, ST_DONE} state_t;

  // Non-negative is tested on the sign bit so the compare never degrades to unsigned.
  function automatic logic in_bounds(input logic signed [COORD_WIDTH-1:0] x,
                                     input logic signed [COORD_WIDTH-1:0] y);
    return !x[COORD_WIDTH-1] && (x < X_LIMIT) && !y[COORD_WIDTH-1] && (y < Y_LIMIT);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t                  state_q, state_d;
  logic                    drain_q, drain_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [COLOR_WIDTH-1:0]  fill_q, fill_d;
  logic [15:0]             clip_q, clip_d;
  logic [15:0]             drop_q, drop_d;
  logic                    vld_p1_q, vld_p1_d;
  logic [ADDR_WIDTH-1:0]   x_p1_q, x_p1_d;
  logic [ADDR_WIDTH-1:0]   y_p1_q, y_p1_d;
  logic [COLOR_WIDTH-1:0]  color_p1_q, color_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic [ADDR_WIDTH-1:0]   addr_p2_q, addr_p2_d;
  logic [COLOR_WIDTH-1:0]  data_p2_q, data_p2_d;
  logic                    pix_in_bounds;
  logic                    is_idle;

  always_comb begin
    pix_in_bounds = in_bounds(x_in, y_in);
    is_idle       = (state_q == ST_IDLE);
    state_d       = state_q;
    drain_d       = drain_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    fill_d        = fill_q;
    clip_d        = clip_q;
    drop_d        = drop_q;

    // Stage 1: capture and clip; the pipeline only admits pixels in IDLE
    // and a pixel colliding with an accepted start_clear loses.
    vld_p1_d   = is_idle && !start_clear && drawing_in && pix_in_bounds;
    x_p1_d     = x_in[ADDR_WIDTH-1:0];
    y_p1_d     = y_in[ADDR_WIDTH-1:0];
    color_p1_d = color_in;
    if (drawing_in) begin
      if (!is_idle || start_clear) begin
        drop_d = sat_inc(drop_q);
      end else if (!pix_in_bounds) begin
        clip_d = sat_inc(clip_q);
      end
    end

    // Stage 2: linear address; the sweep overrides this path once drained.
    vld_p2_d  = vld_p1_q;
    addr_p2_d = addr_p2_q;
    data_p2_d = data_p2_q;
    if (vld_p1_q) begin
      addr_p2_d = y_p1_q * ROW_PITCH + x_p1_q;
      data_p2_d = color_p1_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_clear) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
          busy_d  = 1'b1;
          fill_d  = clear_color;
        end
      end
      ST_DRAIN: begin
        // Two cycles flush whatever was already in stages 1 and 2.
        if (drain_q) begin
          state_d   = ST_SWEEP;
          vld_p2_d  = 1'b1;
          addr_p2_d = '0;
          data_p2_d = fill_q;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (addr_p2_q == LAST_ADDR) begin
          state_d   = ST_DONE;
          vld_p2_d  = 1'b0;
          addr_p2_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          vld_p2_d  = 1'b1;
          addr_p2_d = addr_p2_q + ADDR_WIDTH'(1);
          data_p2_d = fill_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clip_q    <= '0;
      drop_q    <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
      data_p2_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clip_q    <= clip_d;
      drop_q    <= drop_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      addr_p2_q <= addr_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  // Stage-1 payload and fill colour are qualified by valid/state, so no reset.
  always_ff @(posedge clk_in) begin
    x_p1_q     <= x_p1_d;
    y_p1_q     <= y_p1_d;
    color_p1_q <= color_p1_d;
    fill_q     <= fill_d;
  end

  assign addr_out   = addr_p2_q;
  assign data_out   = data_p2_q;
  assign we_out     = vld_p2_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign clip_count = clip_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;
  localparam int W = 320;
  localparam int H = 180;
  localparam int N = W * H;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [31:0] x_in, y_in;
  logic               drawing_in;
  logic [15:0]        color_in;
  logic               start_clear;
  logic [15:0]        clear_color;
  logic [15:0]        addr_out, data_out;
  logic               we_out, busy, done;
  logic [15:0]        clip_count, drop_count;

  always #5 clk_in = ~clk_in;

  framebuffer_writer dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .drawing_in(drawing_in), .color_in(color_in), .start_clear(start_clear),
    .clear_color(clear_color), .addr_out(addr_out), .data_out(data_out),
    .we_out(we_out), .busy(busy), .done(done),
    .clip_count(clip_count), .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int clip_model = 0;
  int drop_model = 0;

  typedef struct {
    int          x;
    int          y;
    bit          draw;
    logic [15:0] col;
    bit          exp_we;
    int          exp_addr;
  } vec_t;

  typedef struct {
    int          t;
    int          addr;
    logic [15:0] data;
  } wr_t;

  vec_t tbl[17];
  wr_t  sched[$];
  wr_t  w;
  int   rx, ry, bad, first_bad, guard, done_cnt;
  bit   rd;
  logic [15:0] rc;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic drive_pix(input int x, input int y, input bit d, input logic [15:0] c);
    x_in       = x;
    y_in       = y;
    drawing_in = d;
    color_in   = c;
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Compares the write port against the scheduled model writes for this cycle.
  task automatic compare_cycle();
    if (sched.size() > 0 && sched[0].t == cyc) begin
      w = sched.pop_front();
      check("rand_we", we_out, 1);
      check("rand_addr", addr_out, w.addr);
      check("rand_data", data_out, w.data);
    end else begin
      check("rand_idle_we", we_out, 0);
    end
  endtask

  initial begin
    tbl[0]  = '{5, 2, 1'b1, 16'hF800, 1'b1, 645};
    tbl[1]  = '{-1, 0, 1'b1, 16'h0001, 1'b0, 0};
    tbl[2]  = '{320, 0, 1'b1, 16'h0002, 1'b0, 0};
    tbl[3]  = '{0, 180, 1'b1, 16'h0003, 1'b0, 0};
    tbl[4]  = '{32'hFFFFFFFF, 5, 1'b1, 16'h0004, 1'b0, 0};
    tbl[5]  = '{-1, 0, 1'b0, 16'h0001, 1'b0, 0};
    tbl[6]  = '{320, 0, 1'b0, 16'h0002, 1'b0, 0};
    tbl[7]  = '{0, 180, 1'b0, 16'h0003, 1'b0, 0};
    tbl[8]  = '{32'hFFFFFFFF, 5, 1'b0, 16'h0004, 1'b0, 0};
    tbl[9]  = '{319, 179, 1'b1, 16'h1234, 1'b1, 57599};
    tbl[10] = '{0, 0, 1'b1, 16'hABCD, 1'b1, 0};
    tbl[11] = '{319, 0, 1'b1, 16'h5555, 1'b1, 319};
    tbl[12] = '{0, 179, 1'b1, 16'hAAAA, 1'b1, 57280};
    tbl[13] = '{32'h7FFFFFFF, 0, 1'b1, 16'h0005, 1'b0, 0};
    tbl[14] = '{0, 32'h80000000, 1'b1, 16'h0006, 1'b0, 0};
    tbl[15] = '{5, -1, 1'b1, 16'h0007, 1'b0, 0};
    tbl[16] = '{7, 3, 1'b0, 16'h0008, 1'b0, 0};

    rst_in      = 1'b0;
    start_clear = 1'b0;
    clear_color = 16'h0000;
    drive_pix(0, 0, 1'b0, 16'h0000);
    repeat (3) tick();
    check("rst_we", we_out, 0);
    check("rst_addr", addr_out, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clip", clip_count, 0);
    check("rst_drop", drop_count, 0);
    #2 rst_in = 1'b1;
    tick();

    // Single pixels: latency, address mapping and clipping.
    for (int i = 0; i < 17; i++) begin
      drive_pix(tbl[i].x, tbl[i].y, tbl[i].draw, tbl[i].col);
      if (tbl[i].draw && !tbl[i].exp_we) clip_model = sat16(clip_model);
      tick();
      drawing_in = 1'b0;
      tick();
      check($sformatf("vec%0d_we", i), we_out, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), addr_out, tbl[i].exp_addr);
        check($sformatf("vec%0d_data", i), data_out, tbl[i].col);
      end
      tick();
      check($sformatf("vec%0d_we_after", i), we_out, 0);
      check($sformatf("vec%0d_clip", i), clip_count, clip_model);
    end

    // Back-to-back burst along the bottom row.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive_pix(i, 179, 1'b1, 16'(16'h0100 + i));
      else        drawing_in = 1'b0;
      tick();
      if (i >= 1) begin
        check($sformatf("burst%0d_we", i - 1), we_out, 1);
        check($sformatf("burst%0d_addr", i - 1), addr_out, 57280 + i - 1);
        check($sformatf("burst%0d_data", i - 1), data_out, 16'h0100 + i - 1);
      end
    end
    tick();
    check("burst_end_we", we_out, 0);

    // Randomised pixel stream against the scheduled-write model.
    sched.delete();
    for (int n = 0; n < 1500; n++) begin
      rx = ($urandom_range(0, 15) == 0) ? int'($urandom()) : int'($urandom_range(0, 359)) - 20;
      ry = ($urandom_range(0, 15) == 0) ? int'($urandom()) : int'($urandom_range(0, 199)) - 10;
      rd = ($urandom_range(0, 3) != 0);
      rc = 16'($urandom());
      drive_pix(rx, ry, rd, rc);
      if (rd && on_screen(rx, ry)) sched.push_back('{cyc + 2, ry * W + rx, rc});
      else if (rd)                 clip_model = sat16(clip_model);
      tick();
      compare_cycle();
    end
    drawing_in = 1'b0;
    repeat (3) begin
      tick();
      compare_cycle();
    end
    check("rand_sched_empty", sched.size(), 0);
    check("rand_clip", clip_count, clip_model);
    check("rand_drop", drop_count, drop_model);

    // Clear: pixel just before start completes; pixel with start is dropped.
    drive_pix(1, 1, 1'b1, 16'h7777);
    tick();
    drive_pix(2, 2, 1'b1, 16'h2222);
    start_clear = 1'b1;
    clear_color = 16'h001F;
    drop_model  = sat16(drop_model);
    tick();
    start_clear = 1'b0;
    clear_color = 16'h0000;
    drawing_in  = 1'b0;
    check("clr_pix_we", we_out, 1);
    check("clr_pix_addr", addr_out, 321);
    check("clr_pix_data", data_out, 16'h7777);
    check("clr_busy_drain", busy, 1);
    tick();
    check("clr_drain_we", we_out, 0);
    check("clr_drain_busy", busy, 1);
    bad = 0;
    first_bad = -1;
    for (int a = 0; a < N; a++) begin
      tick();
      if (we_out !== 1'b1 || int'(addr_out) != a || data_out !== 16'h001F ||
          busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
      drawing_in  = 1'b0;
      start_clear = 1'b0;
      if (a == 100 || a == 101 || a == 5000) begin
        drive_pix(10, 10, 1'b1, 16'hBEEF);
        drop_model = sat16(drop_model);
      end
      if (a == 300) begin
        drive_pix(400, 10, 1'b1, 16'hDEAD);
        drop_model = sat16(drop_model);
      end
      if (a == 200) begin
        start_clear = 1'b1;
        clear_color = 16'hF0F0;
      end
    end
    drawing_in  = 1'b0;
    start_clear = 1'b0;
    check($sformatf("sweep_bad_cycles_first_%0d", first_bad), bad, 0);
    tick();
    check("clr_done", done, 1);
    check("clr_done_busy", busy, 0);
    check("clr_done_we", we_out, 0);
    tick();
    check("clr_done_pulse", done, 0);
    check("clr_idle_busy", busy, 0);
    drive_pix(3, 0, 1'b1, 16'h0C0C);
    tick();
    drawing_in = 1'b0;
    tick();
    check("post_clr_we", we_out, 1);
    check("post_clr_addr", addr_out, 3);
    check("post_clr_data", data_out, 16'h0C0C);
    check("clr_drop", drop_count, drop_model);
    check("clr_clip", clip_count, clip_model);

    // Reset in the middle of a sweep.
    start_clear = 1'b1;
    clear_color = 16'h0F0F;
    tick();
    start_clear = 1'b0;
    guard = 0;
    while (!(we_out === 1'b1 && addr_out == 16'd1000) && guard < 2000) begin
      tick();
      guard++;
    end
    check("reach_addr_1000", (guard < 2000), 1);
    #2 rst_in = 1'b0;
    #1;
    check("arst_we", we_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_addr", addr_out, 0);
    tick();
    tick();
    check("arst_clip", clip_count, 0);
    check("arst_drop", drop_count, 0);
    clip_model = 0;
    drop_model = 0;
    #2 rst_in = 1'b1;
    drive_pix(0, 0, 1'b1, 16'h1111);
    tick();
    drawing_in = 1'b0;
    tick();
    check("arst_pix_we", we_out, 1);
    check("arst_pix_addr", addr_out, 0);
    check("arst_pix_data", data_out, 16'h1111);
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    check("arst_no_done", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
